// File: rtl/ifport_multichan_checker_if.sv
// rtl/ifport_multichan_checker_if.sv - control/status and per-channel transaction bundle for the checker
interface ifport_multichan_checker_if #(
   parameter int WIDTH = 8,
   parameter int NCHAN = 4
);
   localparam int FCW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   logic                         start;
   logic [NCHAN-1:0]             stall;
   logic [NCHAN-1:0]             inject;
   logic                         busy;
   logic                         done;
   logic                         pass;
   logic [15:0]                  err_count;
   logic [FCW-1:0]               fail_chan;
   // issued transactions as they appear on the wire, observable for debug
   logic [NCHAN-1:0]             tvalid;
   logic [NCHAN-1:0][WIDTH-1:0]  tdata;

   modport master (
      output start, stall, inject,
      input  busy, done, pass, err_count, fail_chan, tvalid, tdata
   );

   modport slave (
      input  start, stall, inject,
      output busy, done, pass, err_count, fail_chan, tvalid, tdata
   );
endinterface

// File: rtl/ifport_multichan_checker.sv
// rtl/ifport_multichan_checker.sv - multi-channel LFSR transaction generator with 1-cycle scoreboard
// Each channel issues NTESTS Galois-LFSR words; a registered compare stage counts mismatches.
module ifport_multichan_checker #(
   parameter int          WIDTH  = 8,
   parameter int          NCHAN  = 4,
   parameter int          NTESTS = 16,
   parameter logic [31:0] SEED   = 32'hA5,
   parameter logic [31:0] POLY   = 32'hB8
) (
   input logic                     clk,
   input logic                     rst,
   ifport_multichan_checker_if.slave bus
);
   localparam int FCW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] lfsr    [NCHAN];
   logic [15:0]      cnt     [NCHAN];
   logic [WIDTH-1:0] chk_val [NCHAN];
   logic [WIDTH-1:0] chk_exp [NCHAN];
   logic [NCHAN-1:0] chk_vld;
   logic [NCHAN-1:0] issue;
   logic [NCHAN-1:0] mis;
   logic [15:0]      err_count;
   logic [FCW-1:0]   fail_chan;
   logic [FCW-1:0]   first_mis;
   logic             fail_seen;
   logic             go;
   logic             last_issue;
   logic [4:0]       nmis;
   logic [16:0]      err_sum;

   function automatic logic [WIDTH-1:0] seed_of(input int c);
      logic [WIDTH-1:0] s;
      s = WIDTH'(SEED) ^ WIDTH'(c);
      return (s == '0) ? WIDTH'(1) : s;
   endfunction

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
      return x[0] ? ((x >> 1) ^ WIDTH'(POLY)) : (x >> 1);
   endfunction

   function automatic logic chk(input logic [WIDTH-1:0] val, input logic [WIDTH-1:0] exp);
      return val == exp;
   endfunction

   always_comb begin
      go         = bus.start && (state == IDLE || state == DONE);
      last_issue = (state == RUN);
      issue      = '0;
      mis        = '0;
      nmis       = '0;
      first_mis  = '0;
      bus.tvalid = '0;
      bus.tdata  = '0;
      // descending scan so the lowest mismatching channel is the one left in first_mis
      for (int c = NCHAN - 1; c >= 0; c--) begin
         issue[c]      = (state == RUN) && !bus.stall[c] && (cnt[c] < 16'(NTESTS));
         bus.tvalid[c] = issue[c];
         bus.tdata[c]  = lfsr[c] ^ WIDTH'(bus.inject[c]);
         mis[c]        = chk_vld[c] && !chk(chk_val[c], chk_exp[c]);
         if (mis[c]) first_mis = FCW'(c);
         nmis = nmis + 5'(mis[c]);
         if (!((cnt[c] == 16'(NTESTS)) || (issue[c] && cnt[c] == 16'(NTESTS - 1))))
            last_issue = 1'b0;
      end
      err_sum = {1'b0, err_count} + 17'(nmis);
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.start) state_n = RUN;
         RUN:     if (last_issue) state_n = DRAIN;
         DRAIN:   state_n = DONE;
         DONE:    if (bus.start) state_n = RUN;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         err_count <= '0;
         fail_chan <= '0;
         fail_seen <= 1'b0;
         chk_vld   <= '0;
         for (int c = 0; c < NCHAN; c++) begin
            lfsr[c]    <= seed_of(c);
            cnt[c]     <= '0;
            chk_val[c] <= '0;
            chk_exp[c] <= '0;
         end
      end else begin
         state <= state_n;
         if (go) begin
            err_count <= '0;
            fail_chan <= '0;
            fail_seen <= 1'b0;
            chk_vld   <= '0;
            for (int c = 0; c < NCHAN; c++) begin
               lfsr[c] <= seed_of(c);
               cnt[c]  <= '0;
            end
         end else begin
            chk_vld <= issue;
            for (int c = 0; c < NCHAN; c++) begin
               if (issue[c]) begin
                  chk_val[c] <= bus.tdata[c];
                  chk_exp[c] <= lfsr[c];
                  lfsr[c]    <= step(lfsr[c]);
                  cnt[c]     <= cnt[c] + 16'd1;
               end
            end
            if (nmis != '0) begin
               err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
               if (!fail_seen) begin
                  fail_chan <= first_mis;
                  fail_seen <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.busy      = (state == RUN) || (state == DRAIN);
   assign bus.done      = (state == DONE);
   assign bus.pass      = (state == DONE) && (err_count == '0);
   assign bus.err_count = err_count;
   assign bus.fail_chan = fail_chan;
endmodule
